// File: rtl/demux_capture_4ch_pkg.sv
// rtl/demux_capture_4ch_pkg.sv - shared constants and lane state encoding for demux_capture_4ch
package demux_cap_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

endpackage

// File: rtl/demux_capture_4ch_if.sv
// rtl/demux_capture_4ch_if.sv - routed-bit input and per-channel word stream bundle
interface demux_capture_4ch_if #(
    parameter int WIDTH = 8
);
    import demux_cap_pkg::*;

    logic                      bit_vld;
    logic [SEL_W-1:0]          sel;
    logic                      y0;
    logic                      y1;
    logic                      y2;
    logic                      y3;
    logic [NUM_CH-1:0]         ch_rdy;
    logic                      ovf_clr;
    logic [NUM_CH-1:0]         ch_vld;
    logic [NUM_CH*WIDTH-1:0]   ch_data;
    logic [NUM_CH-1:0]         ovf;
    logic                      err;

    modport master (
        output bit_vld, sel, y0, y1, y2, y3, ch_rdy, ovf_clr,
        input  ch_vld, ch_data, ovf, err
    );

    modport slave (
        input  bit_vld, sel, y0, y1, y2, y3, ch_rdy, ovf_clr,
        output ch_vld, ch_data, ovf, err
    );

endinterface

// File: rtl/demux_capture_4ch_lane.sv
// rtl/demux_capture_4ch_lane.sv - one channel: bit assembler, word holding register, overflow flag
module demux_cap_lane
    import demux_cap_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cap_en,
    input  logic             bit_in,
    input  logic             rdy,
    input  logic             clr,
    output logic             vld,
    output logic [WIDTH-1:0] data,
    output logic             ovf
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    // The oldest bit shifts straight into the word on completion, so only WIDTH-1 bits are stored.
    logic [WIDTH-2:0] shreg;
    logic [CNT_W-1:0] cnt;
    logic [0:0]       state;
    logic             complete;
    logic             ovf_set;
    logic [WIDTH-1:0] word;

    assign word     = {shreg, bit_in};
    assign complete = cap_en && (cnt == LAST);
    assign ovf_set  = complete && (state == FULL) && !rdy;
    assign vld      = (state == FULL);

    // Shift in routed bits MSB first and count toward a full word.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (cap_en) begin
            shreg <= word[WIDTH-2:0];
            cnt   <= complete ? '0 : cnt + 1'b1;
        end
    end

    // Hold a completed word until the consumer takes it; a new word into an unready full lane is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            data  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (complete) begin
                        state <= FULL;
                        data  <= word;
                    end
                end
                default: begin
                    if (complete && rdy) begin
                        data <= word;
                    end else if (!complete && rdy) begin
                        state <= EMPTY;
                    end
                end
            endcase
        end
    end

    // Sticky overflow; a set in the same cycle as a clear takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (ovf_set) begin
            ovf <= 1'b1;
        end else if (clr) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: rtl/demux_capture_4ch.sv
// rtl/demux_capture_4ch.sv - four-lane word assembler behind a 1-to-4 bit demux; optional steering check under DEMUX_CAP_CHECK_EN
module demux_capture_4ch
    import demux_cap_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst,
    demux_capture_4ch_if.slave  bus
);

    logic [NUM_CH-1:0] y_vec;
    logic [NUM_CH-1:0] sel_oh;
    logic              routed;

    assign y_vec  = {bus.y3, bus.y2, bus.y1, bus.y0};
    assign sel_oh = NUM_CH'(1) << bus.sel;
    assign routed = y_vec[bus.sel];

    for (genvar n = 0; n < NUM_CH; n++) begin : g_lane
        demux_cap_lane #(
            .WIDTH (WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .cap_en (bus.bit_vld && sel_oh[n]),
            .bit_in (routed),
            .rdy    (bus.ch_rdy[n]),
            .clr    (bus.ovf_clr),
            .vld    (bus.ch_vld[n]),
            .data   (bus.ch_data[n*WIDTH +: WIDTH]),
            .ovf    (bus.ovf[n])
        );
    end

`ifdef DEMUX_CAP_CHECK_EN
    logic viol;
    logic err_q;

    assign viol    = bus.bit_vld && |(y_vec & ~sel_oh);
    assign bus.err = err_q;

    // Latch any cycle where the demux drove an output other than the selected one.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (viol) begin
            err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Report each steering violation with the offending select and outputs.
    always_ff @(posedge clk) begin
        if (!rst && viol) begin
            $display("demux_capture_4ch: steering violation sel=%0d {y0,y1,y2,y3}=%b",
                     bus.sel, {bus.y0, bus.y1, bus.y2, bus.y3});
        end
    end
`endif
`else
    assign bus.err = 1'b0;
`endif

endmodule

// File: doc/demux_capture_4ch.md
Name: demux_capture_4ch

Overview:
- Downstream consumer of the 1-to-4 bit demultiplexer.
- Each routed bit arrives on y0..y3 together with the sel that steered it. The block assembles the bits of each channel, MSB first, into a WIDTH-bit word per channel.
- Each completed word is presented on an independent valid/ready port per channel.
- It converts the demux's per-bit fan-out into word-level streams for the four destination consumers.

Parameters:
- WIDTH, 8, bits per assembled word; legal range 2..32.
- NUM_CH, 4, channel count; fixed at 4 and not overridable, because it must match the demux.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- bit_vld  input  1  y0..y3 and sel carry a valid routed bit this cycle.
- sel  input  2  channel the demux steered the bit to.
- y0  input  1  demux output 0.
- y1  input  1  demux output 1.
- y2  input  1  demux output 2.
- y3  input  1  demux output 3.
- ch_rdy  input  4  per-channel consumer ready; bit n belongs to channel n.
- ovf_clr  input  1  clears all ovf bits.
- ch_vld  output  4  per-channel word valid.
- ch_data  output  4*WIDTH  channel n word at [n*WIDTH +: WIDTH].
- ovf  output  4  sticky per-channel overflow.
- err  output  1  sticky steering-error flag; see Optional Feature.

Behaviour:
- Clock and reset: one clock domain (clk). rst is synchronous and active-high.
- Reset values:
  - ch_vld=0, ch_data=0, ovf=0, err=0.
  - All shift registers and bit counters are 0; all lanes are EMPTY.
  - A reset mid-word discards any partial word and any held word.
- Bit capture:
  - On a cycle with bit_vld=1, only lane sel captures a bit. The captured bit is y[sel].
  - Capture: shreg <= {shreg[WIDTH-2:0], y[sel]}; cnt <= cnt+1.
  - Lanes other than sel are unchanged.
  - bit_vld=0 leaves every shift register and counter unchanged; there is no timeout.
- Word completion:
  - A word completes when the bit is captured while cnt==WIDTH-1.
  - The completed word is {shreg[WIDTH-2:0], y[sel]}. cnt wraps to 0.
- Per-lane holding state machine:
  - EMPTY --complete--> FULL; ch_data loads the word and ch_vld=1 on the next cycle (latency 1 clock after the last bit).
  - FULL --ch_rdy=1--> EMPTY, unless a completion occurs in the same cycle.
  - FULL, with complete and ch_rdy=1 in the same cycle: stay FULL and load the new word. No overflow.
  - FULL, with complete and ch_rdy=0: the new word is dropped, the held word is kept, and ovf[n] is set. The lane stays FULL.
- Holding register: ch_data[n] is stable while ch_vld[n]=1 and ch_rdy[n]=0. ch_data retains its last value when EMPTY.
- ch_rdy while EMPTY is ignored.
- ovf:
  - ovf_clr=1 clears all ovf bits.
  - If a set condition and ovf_clr occur in the same cycle, the set wins.
- Lanes are fully independent. Interleaved sel values build four words concurrently.

Optional Feature:
- Macro: DEMUX_CAP_CHECK_EN.
- Defined:
  - With bit_vld=1, any y[k]=1 for k != sel sets err. This means the demux drove a non-selected output.
  - err is sticky until rst. Capture proceeds normally regardless.
  - Under simulation (SYNTHESIS undefined), each violation is also reported with $display, showing sel and {y0,y1,y2,y3}.
- Undefined: err is tied to 0 and no checking logic is generated.

Decomposition:
- Shared package demux_cap_pkg:
  - Constants: NUM_CH=4, SEL_W=2.
  - Lane state encoding: EMPTY=1'b0, FULL=1'b1.
- Sub-module demux_cap_lane:
  - One instance per channel, instantiated 4x.
  - Contains the shift register, bit counter, holding register, state and ovf bit.
  - Inputs: cap_en (bit_vld && sel==n), the routed bit, rdy and clr.
- Top-level logic: sel decode, y[sel] mux, and the optional check.

Test Plan:
1. Reset, then WIDTH=8, sel=2, send bits 1,0,1,0,0,1,0,1 with ch_rdy=4'b1111 -> ch_vld=4'b0100 one cycle after the 8th bit, ch_data[23:16]=8'hA5, ch_vld[2] drops next cycle.
2. Interleave sel=0 bits of 8'hFF with sel=3 bits of 8'h3C alternately (16 bit_vld cycles) -> ch_data[7:0]=8'hFF and ch_data[31:24]=8'h3C, each valid independently; lanes 1 and 2 untouched.
3. sel=1, ch_rdy[1]=0: complete 8'h11, then 8'h22 -> ch_data[15:8] stays 8'h11, ovf=4'b0010. Pulse ovf_clr -> ovf=0.
4. Lane 1 FULL with 8'h11; complete 8'h33 in the same cycle ch_rdy[1]=1 -> ch_vld[1] stays 1, ch_data[15:8]=8'h33, ovf[1]=0.
5. Send 5 bits to sel=0, assert rst for 1 cycle, then send 8 bits of 8'h81 -> word 8'h81 (no residue from the partial word), all outputs 0 during reset.
6. With DEMUX_CAP_CHECK_EN defined: bit_vld=1, sel=0, {y0,y1,y2,y3}=4'b0100 -> err=1 and stays 1. Without the macro, the same stimulus -> err=0.
